// File: rtl/cmp_pkg.sv
// Shared definitions for the frame statistics block.
// Holds the controller state encoding, the sample width and the default
// frame length used by cmp_frame_stats and its bench.
package cmp_pkg;

  localparam int SAMPLE_W      = 4;
  localparam int FRAME_LEN_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no sample held
    ACCUM = 2'd1,  // 1..FRAME_LEN-1 samples taken
    HOLD  = 2'd2   // frame result presented
  } state_e;

endpackage

// File: rtl/comparator4bit.sv
// 4-bit unsigned magnitude comparator.
// Ports:
//   a_i, b_i : operands
//   e_o      : a_i == b_i
//   g_o      : a_i >  b_i
//   l_o      : a_i <  b_i
module comparator4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       e_o,
  output logic       g_o,
  output logic       l_o
);

  assign e_o = (a_i == b_i);
  assign g_o = (a_i >  b_i);
  assign l_o = (a_i <  b_i);

endmodule

// File: rtl/cmp_frame_stats.sv
// Frame statistics: collects FRAME_LEN 4-bit samples and reports the frame
// maximum, minimum and the number of samples strictly greater than their
// predecessor.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   in_data      : sample, in_valid / in_ready handshake
//   flush        : discard partial frame or held result (highest priority)
//   max_out      : frame maximum      (0 when out_valid=0)
//   min_out      : frame minimum      (0 when out_valid=0)
//   rise_cnt     : rising-sample count (0 when out_valid=0)
//   out_valid    : result presented, consumed with out_ready
//   state_o      : controller state, for observation only
//
// Handshake: a transfer happens in a cycle where valid and ready are both 1.
// in_ready does not depend on in_valid; out_valid does not depend on
// out_ready. A presented result stays stable until it is taken or flushed.
module cmp_frame_stats
  import cmp_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [SAMPLE_W-1:0] max_out,
  output logic [SAMPLE_W-1:0] min_out,
  output logic [3:0]          rise_cnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          state_o
);

  // Count value just before the final accept of a frame.
  localparam logic [3:0] LAST_CNT = 4'(FRAME_LEN - 1);

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] max_q, max_d;
  logic [SAMPLE_W-1:0] min_q, min_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          rise_q, rise_d;

  logic accept;
  logic max_e, max_g, max_l;
  logic min_e, min_g, min_l;
  logic prv_e, prv_g, prv_l;

  comparator4bit u_cmp_max (.a_i(in_data), .b_i(max_q),  .e_o(max_e), .g_o(max_g), .l_o(max_l));
  comparator4bit u_cmp_min (.a_i(in_data), .b_i(min_q),  .e_o(min_e), .g_o(min_g), .l_o(min_l));
  comparator4bit u_cmp_prv (.a_i(in_data), .b_i(prev_q), .e_o(prv_e), .g_o(prv_g), .l_o(prv_l));

  // Only the strict-greater / strict-less results steer updates; equality
  // means "no change", so the remaining outputs are deliberately sunk here.
  logic unused_cmp;
  assign unused_cmp = ^{max_e, max_l, min_e, min_g, prv_e, prv_l};

  assign in_ready  = (state_q != HOLD) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign max_out   = out_valid ? max_q  : '0;
  assign min_out   = out_valid ? min_q  : '0;
  assign rise_cnt  = out_valid ? rise_q : '0;
  assign state_o   = state_q;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    rise_d  = rise_q;
    if (flush) begin
      state_d = IDLE;
      max_d   = '0;
      min_d   = '0;
      prev_d  = '0;
      cnt_d   = '0;
      rise_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            max_d   = in_data;
            min_d   = in_data;
            prev_d  = in_data;
            cnt_d   = 4'd1;
            rise_d  = '0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (max_g) max_d = in_data;
            if (min_l) min_d = in_data;
            // At most FRAME_LEN-1 increments per frame, so no wrap in 4 bits.
            if (prv_g) rise_d = rise_q + 4'd1;
            prev_d = in_data;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            max_d   = '0;
            min_d   = '0;
            prev_d  = '0;
            cnt_d   = '0;
            rise_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      max_q   <= '0;
      min_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

endmodule

// File: tb/tb_cmp_frame_stats.sv
// Bench for cmp_frame_stats with FRAME_LEN=4: directed frames, a
// frame-level reference model checked every cycle, and a queue of
// hand-computed frame results checked at each output handshake.
module tb_cmp_frame_stats;
  import cmp_pkg::*;

  localparam int FL = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [3:0] max_out, min_out, rise_cnt;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  cmp_frame_stats #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .max_out(max_out), .min_out(min_out),
    .rise_cnt(rise_cnt), .out_valid(out_valid), .out_ready(out_ready),
    .state_o(state_o)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: the samples of the current frame sit in a queue; when
  // it fills, the statistics are computed from the whole frame at once.
  logic [3:0] frame_q[$];
  bit         holding = 1'b0;
  int         h_max = 0, h_min = 0, h_rise = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      frame_q.delete();
      holding = 1'b0;
    end else if (flush) begin
      frame_q.delete();
      holding = 1'b0;
    end else if (holding) begin
      if (out_ready) holding = 1'b0;
    end else if (in_valid) begin
      frame_q.push_back(in_data);
      if (frame_q.size() == FL) begin
        h_max = frame_q[0]; h_min = frame_q[0]; h_rise = 0;
        for (int i = 1; i < FL; i++) begin
          if (frame_q[i] > h_max) h_max = frame_q[i];
          if (frame_q[i] < h_min) h_min = frame_q[i];
          if (frame_q[i] > frame_q[i-1]) h_rise++;
        end
        holding = 1'b1;
        frame_q.delete();
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Hand-computed {max, min, rise} of each frame expected to be consumed.
  logic [11:0] exp_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] exp_state;
      exp_state = holding ? HOLD : ((frame_q.size() != 0) ? ACCUM : IDLE);
      check("in_ready",  in_ready,  (!holding && !flush) ? 1 : 0);
      check("out_valid", out_valid, holding ? 1 : 0);
      check("max_out",   max_out,   holding ? h_max  : 0);
      check("min_out",   min_out,   holding ? h_min  : 0);
      check("rise_cnt",  rise_cnt,  holding ? h_rise : 0);
      check("state",     state_o,   exp_state);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("frame_result", {max_out, min_out, rise_cnt}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two cycles.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs",   {max_out, min_out, rise_cnt}, 0);
    idle(1);

    // Basic frame 3,9,1,9.
    exp_q.push_back({4'd9, 4'd1, 4'd2});
    send4(4'd3, 4'd9, 4'd1, 4'd9);
    wait_valid("basic");
    check("basic_max",  max_out,  9);
    check("basic_min",  min_out,  1);
    check("basic_rise", rise_cnt, 2);
    check("model_basic", {h_max, h_min, h_rise}, {32'd9, 32'd1, 32'd2});
    take();
    check("basic_cleared", out_valid, 0);

    // All-equal frame.
    exp_q.push_back({4'd5, 4'd5, 4'd0});
    send4(4'd5, 4'd5, 4'd5, 4'd5);
    wait_valid("equal");
    check("equal_rise", rise_cnt, 0);
    take();

    // Backpressure with in_valid held high.
    exp_q.push_back({4'd8, 4'd2, 4'd3});
    send4(4'd2, 4'd4, 4'd6, 4'd8);
    wait_valid("bp");
    in_valid = 1'b1;
    in_data  = 4'd15;
    idle(5);
    check("bp_in_ready", in_ready, 0);
    check("bp_max",      max_out,  8);
    in_valid = 1'b0;
    take();
    check("bp_released", out_valid, 0);
    idle(1);

    // Flush mid-frame, with in_valid high during the flush.
    send(4'd7); send(4'd7);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd7;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_idle", state_o, IDLE);
    exp_q.push_back({4'd15, 4'd0, 4'd1});
    send4(4'd0, 4'd15, 4'd15, 4'd0);
    wait_valid("flush");
    check("model_flush", {h_max, h_min, h_rise}, {32'd15, 32'd0, 32'd1});
    take();

    // Reset mid-frame.
    send(4'd1); send(4'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    exp_q.push_back({4'd4, 4'd1, 4'd0});
    send4(4'd4, 4'd3, 4'd2, 4'd1);
    wait_valid("midrst");
    take();

    // Flush drops a held result without a handshake.
    send4(4'd1, 4'd1, 4'd1, 4'd2);
    wait_valid("hold_flush");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("hold_flush_dropped", out_valid, 0);

    // Maximum rise count for this frame length.
    exp_q.push_back({4'd4, 4'd1, 4'd3});
    send4(4'd1, 4'd2, 4'd3, 4'd4);
    wait_valid("max_rise");
    take();

    // Reset while holding a result.
    send4(4'd15, 4'd0, 4'd15, 4'd0);
    wait_valid("hold_rst");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("hold_rst_cleared", {out_valid, max_out, min_out, rise_cnt}, 0);
    idle(2);

    check("exp_q_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmp_frame_stats.md
CMP_FRAME_STATS -- requirements
Module: cmp_frame_stats

Interface
REQ-001 Parameter FRAME_LEN, default 8, number of 4-bit samples per frame; legal range 2..15.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset: clk and rst_n.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 in_data  in  4  unsigned sample.
REQ-006 in_valid  in  1  in_data is valid this cycle.
REQ-007 in_ready  out  1  block accepts a sample this cycle.
REQ-008 flush  in  1  synchronous discard of the partial frame or held result.
REQ-009 max_out  out  4  largest sample of the completed frame.
REQ-010 min_out  out  4  smallest sample of the completed frame.
REQ-011 rise_cnt  out  4  count of samples strictly greater than their predecessor in the frame.
REQ-012 out_valid  out  1  frame result is presented.
REQ-013 out_ready  in  1  consumer takes the result.

Function
REQ-014 A sample SHALL be accepted only in a cycle where in_valid=1, in_ready=1 and flush=0.
REQ-015 The FSM SHALL have three states: IDLE (no sample held), ACCUM (1..FRAME_LEN-1 samples taken) and HOLD (result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD, and 0 in any cycle with flush=1.
REQ-017 IDLE accept: max, min and prev load the sample; count=1; rise=0; next state ACCUM.
REQ-018 ACCUM accept: the following updates apply in the same edge, and count increments.
- max loads the sample if sample>max.
- min loads the sample if sample<min.
- rise increments if sample>prev.
- prev loads the sample.
REQ-019 Equal comparisons SHALL cause no update to max, min or rise.
REQ-020 When the accept makes count equal FRAME_LEN, the next state SHALL be HOLD, and out_valid SHALL be 1 in the cycle after that final accept (1-cycle latency).
REQ-021 In HOLD, max_out, min_out and rise_cnt SHALL be stable, and in_valid SHALL be ignored.
REQ-022 In HOLD with out_ready=1, the next state SHALL be IDLE, and out_valid SHALL be 0 the following cycle.
REQ-023 Outputs max_out, min_out and rise_cnt SHALL be 0 whenever out_valid=0.
REQ-024 flush=1 in any state SHALL force IDLE next cycle, clear all counters, and drop any held result without handshake; flush has priority over accept and out_ready.
REQ-025 rise SHALL never exceed FRAME_LEN-1 (at most 14), so it fits 4 bits without wrap.

Reset
REQ-026 rst_n=0 at a clk edge SHALL force IDLE and zero max, min, prev, count, rise, out_valid, max_out, min_out and rise_cnt, including mid-frame or in HOLD.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-028 A shared package cmp_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD), the sample width constant (4) and the FRAME_LEN default.
REQ-029 The magnitude compares SHALL use three instances of the team's existing comparator4bit (e/g/l outputs): sample vs max, sample vs min, and sample vs prev; no other sub-module.

Verification (FRAME_LEN=4)
REQ-030 Reset: hold rst_n=0 for 2 cycles -> out_valid=0, all outputs 0, in_ready=1 after release.
REQ-031 Basic frame: stream 3,9,1,9 back-to-back -> one cycle after the 4th accept, out_valid=1, max_out=9, min_out=1, rise_cnt=2.
REQ-032 All-equal frame: 5,5,5,5 -> max_out=5, min_out=5, rise_cnt=0.
REQ-033 Backpressure: after frame 2,4,6,8, hold out_ready=0 for 5 cycles while driving in_valid=1 -> outputs stay 8/2/3, in_ready=0, nothing accepted; out_ready=1 -> IDLE, out_valid=0 next cycle.
REQ-034 Flush mid-frame: 7,7, then flush=1 with in_valid=1, then 0,15,15,0 -> only the last frame is reported: max_out=15, min_out=0, rise_cnt=1.
REQ-035 Reset mid-frame: after 2 samples, pulse rst_n=0 -> all state cleared, and the next 4 samples form a complete new frame.
